shift_register: RTL and testbench

- Parameterised universal shift register with asynchronous clear/set, synchronous clear/set, parallel load and serial shift in a configurable direction.
- Provides a serial output of the bit at the outgoing end.
- Building block for datapath serialisers and deserialisers, and for constant-preload registers.

---
 rtl/shift_register.sv | 52 +++++
 tb/tb_shift_register.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/shift_register.sv
// Universal shift register: async clear/set, sync clear/set, parallel load,
// and serial shift toward MSB or LSB, with a serial output at the outgoing end.
module shift_register #(
  parameter int LOAD_AVALUE     = 2,
  parameter int SHIFT_DIRECTION = 1,
  parameter int LOAD_SVALUE     = 4,
  parameter int SHIFT_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   aset,
  input  logic                   sclr,
  input  logic                   sset,
  input  logic                   enable,
  input  logic                   load,
  input  logic                   shiftin,
  input  logic [SHIFT_WIDTH-1:0] data,
  output logic [SHIFT_WIDTH-1:0] q,
  output logic                   shiftout
);

  // Preset values, truncated to the register width.
  localparam logic [SHIFT_WIDTH-1:0] AVALUE = SHIFT_WIDTH'(LOAD_AVALUE);
  localparam logic [SHIFT_WIDTH-1:0] SVALUE = SHIFT_WIDTH'(LOAD_SVALUE);

  // Register update: async clear beats async set; otherwise enabled sync ops.
  always_ff @(posedge clk or posedge aclr or posedge aset) begin
    if (aclr) begin
      q <= '0;
    end else if (aset) begin
      q <= AVALUE;
    end else if (enable) begin
      if (sclr) begin
        q <= '0;
      end else if (sset) begin
        q <= SVALUE;
      end else if (load) begin
        q <= data;
      end else if (SHIFT_DIRECTION != 0) begin
        q <= {q[SHIFT_WIDTH-2:0], shiftin};
      end else begin
        q <= {shiftin, q[SHIFT_WIDTH-1:1]};
      end
    end
  end

  // Serial output is the bit that the next shift will push out.
  always_comb begin
    shiftout = (SHIFT_DIRECTION != 0) ? q[SHIFT_WIDTH-1] : q[0];
  end

endmodule

// File: tb/tb_shift_register.sv
// Testbench for shift_register: one left-shifting and one right-shifting
// instance share stimulus; a reference model pushes expected q/shiftout into
// a queue before each edge, popped and compared on the following negedge.
module tb_shift_register;

  localparam int W = 8;
  localparam logic [W-1:0] AV = 8'd2;
  localparam logic [W-1:0] SV = 8'd4;

  logic clk = 1'b0;
  logic aclr, aset, sclr, sset, enable, load, shiftin;
  logic [W-1:0] data;
  logic [W-1:0] q_l, q_r;
  logic so_l, so_r;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [W-1:0] ql;
    logic [W-1:0] qr;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] m_l, m_r;

  always #5 clk = ~clk;

  shift_register #(
    .LOAD_AVALUE(2), .SHIFT_DIRECTION(1), .LOAD_SVALUE(4), .SHIFT_WIDTH(W)
  ) dut_l (
    .clk(clk), .aclr(aclr), .aset(aset), .sclr(sclr), .sset(sset),
    .enable(enable), .load(load), .shiftin(shiftin), .data(data),
    .q(q_l), .shiftout(so_l)
  );

  shift_register #(
    .LOAD_AVALUE(2), .SHIFT_DIRECTION(0), .LOAD_SVALUE(4), .SHIFT_WIDTH(W)
  ) dut_r (
    .clk(clk), .aclr(aclr), .aset(aset), .sclr(sclr), .sset(sset),
    .enable(enable), .load(load), .shiftin(shiftin), .data(data),
    .q(q_r), .shiftout(so_r)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input bit left);
    if (aclr) return '0;
    if (aset) return AV;
    if (!enable) return cur;
    if (sclr) return '0;
    if (sset) return SV;
    if (load) return data;
    if (left) return {cur[W-2:0], shiftin};
    return {shiftin, cur[W-1:1]};
  endfunction

  // Called just after a negedge with inputs already driven.
  task automatic step(input string tag);
    exp_t e;
    #1;
    if (aclr) begin
      m_l = '0; m_r = '0;
    end else if (aset) begin
      m_l = AV; m_r = AV;
    end
    check({tag, "_so_l_pre"}, 32'(so_l), 32'(m_l[W-1]));
    check({tag, "_so_r_pre"}, 32'(so_r), 32'(m_r[0]));
    e.ql = model_next(m_l, 1'b1);
    e.qr = model_next(m_r, 1'b0);
    sb.push_back(e);
    m_l = e.ql;
    m_r = e.qr;
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({tag, "_q_l"}, 32'(q_l), 32'(e.ql));
    check({tag, "_q_r"}, 32'(q_r), 32'(e.qr));
  endtask

  task automatic rand_sync();
    sclr    = 1'($urandom);
    sset    = 1'($urandom);
    enable  = 1'($urandom);
    load    = 1'($urandom);
    shiftin = 1'($urandom);
    data    = W'($urandom);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    aclr = 1'b1; aset = 1'b0; sclr = 1'b0; sset = 1'b0;
    enable = 1'b0; load = 1'b0; shiftin = 1'b0; data = '0;
    m_l = '0; m_r = '0;
    @(negedge clk);
    check("reset_q_l", 32'(q_l), 32'h0);
    check("reset_q_r", 32'(q_r), 32'h0);
    check("reset_so", 32'({so_l, so_r}), 32'h0);

    // aclr beats aset
    aset = 1'b1;
    for (int unsigned i = 0; i < 50; i++) begin
      rand_sync();
      step("aclr_aset");
    end

    // aset alone
    aclr = 1'b0;
    for (int unsigned i = 0; i < 50; i++) begin
      rand_sync();
      step("aset");
    end

    // sclr beats sset and load
    aset = 1'b0;
    for (int unsigned i = 0; i < 50; i++) begin
      rand_sync();
      sclr = 1'b1; sset = 1'b1; enable = 1'b1;
      step("sclr");
    end

    // sset beats load
    for (int unsigned i = 0; i < 50; i++) begin
      rand_sync();
      sclr = 1'b0; sset = 1'b1; enable = 1'b1;
      step("sset");
    end

    // directed load then shifts
    sclr = 1'b0; sset = 1'b0; enable = 1'b1; load = 1'b1; data = 8'hA5;
    step("load");
    check("load_a5_l", 32'(q_l), 32'hA5);
    load = 1'b0; shiftin = 1'b1;
    step("sh1");
    check("sh1_l", 32'(q_l), 32'h4B);
    check("sh1_r", 32'(q_r), 32'hD2);
    shiftin = 1'b0;
    step("sh2");
    check("sh2_l", 32'(q_l), 32'h96);
    shiftin = 1'b1;
    step("sh3");
    check("sh3_l", 32'(q_l), 32'h2D);

    // hold with enable low
    enable = 1'b0; load = 1'b1; data = 8'hFF;
    for (int unsigned i = 0; i < 3; i++) step("hold");
    check("hold_l", 32'(q_l), 32'h2D);

    // aclr between edges: immediate clear, held until next enabled edge
    #2 aclr = 1'b1;
    #1;
    check("aclr_async_l", 32'(q_l), 32'h0);
    check("aclr_async_r", 32'(q_r), 32'h0);
    m_l = '0; m_r = '0;
    #1 aclr = 1'b0;
    @(negedge clk);
    step("post_aclr_hold");
    check("post_aclr_l", 32'(q_l), 32'h0);
    enable = 1'b1; load = 1'b0; shiftin = 1'b1;
    step("post_aclr_shift");

    // mixed random synchronous traffic
    for (int unsigned i = 0; i < 200; i++) begin
      rand_sync();
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
